signal_checker: RTL and testbench
=================================

Name: signal_checker

Overview:
- Sits directly downstream of signal_generator and consumes its o_data/o_ctrl word stream one word per clock.
- Classifies each byte lane as data character, control character or error against the generator's fixed patterns, and accumulates saturating statistics.
- Runs a lock/unlock state machine on the stream and reports per-word error pulses for the testbench and for on-chip monitoring.

Parameters:
- DATA_WIDTH, 64: word width in bits; multiple of 8.
- CTRL_WIDTH, DATA_WIDTH/8: one control flag per byte lane.
- DATA_CHAR_PATTERN, 8'hAA: expected byte when the lane ctrl flag is 0.
- CTRL_CHAR_PATTERN, 8'h55: expected byte when the lane ctrl flag is 1.
- CNT_WIDTH, 32: width of every statistics counter.
- LOCK_COUNT, 4: consecutive good words required to lock; >=1.
- UNLOCK_ERRORS, 3: consecutive bad words required to lose lock; >=1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- i_valid  in  1  input word qualifier.
- i_data  in  DATA_WIDTH  word from generator; lane k = i_data[8k+7:8k].
- i_ctrl  in  CTRL_WIDTH  bit k = control flag of lane k.
- i_clear  in  1  synchronous clear of statistics counters.
- o_word_count  out  CNT_WIDTH  valid words checked.
- o_data_count  out  CNT_WIDTH  good data lanes.
- o_ctrl_count  out  CNT_WIDTH  good control lanes.
- o_err_count  out  CNT_WIDTH  bad lanes.
- o_err  out  1  one-cycle pulse per bad word.
- o_locked  out  1  high in LOCKED state.

Behaviour:
- Reset (rst=0 at an edge): all counters 0, o_err 0, o_locked 0, FSM in HUNT, consecutive-run counters 0, pipeline valid flags 0.
- Lane rule: lane good if (ctrl=0 and byte==DATA_CHAR_PATTERN) or (ctrl=1 and byte==CTRL_CHAR_PATTERN); otherwise bad. A word is bad if any lane is bad.
- Stage 1, edge N: register i_valid, the per-lane good-data mask, good-ctrl mask and bad mask.
- Stage 2, edge N+1: if the stage-1 word is valid, update counters, o_err and the FSM. Results are visible after edge N+1, i.e. 2-cycle latency from presentation.
- Counter updates: o_word_count += 1; o_data_count, o_ctrl_count and o_err_count each += the popcount of the corresponding mask.
- Every counter saturates at 2^CNT_WIDTH-1 and never wraps. An increment that would overflow loads the maximum value.
- o_err: registered, high for exactly the one cycle following a bad word's stage-2 edge; 0 otherwise, including for invalid words.
- i_valid=0: no counter or FSM change, o_err 0. Gaps do not break consecutive-run counts.
- FSM HUNT:
  - A good word increments good_run; when good_run reaches LOCK_COUNT, go to LOCKED and clear bad_run.
  - A bad word sets good_run to 0.
- FSM LOCKED:
  - A bad word increments bad_run; when bad_run reaches UNLOCK_ERRORS, go to HUNT and clear good_run.
  - A good word sets bad_run to 0.
- o_locked = (state==LOCKED), registered with the state.
- i_clear=1 at an edge: all four counters go to 0. Clear overrides the stage-2 word at the same edge, which is not counted; the stage-1 word is counted normally at the next edge. The FSM, o_err and run counters are unaffected by i_clear.
- Reset mid-stream: the in-flight stage-1 word is discarded and all state returns to reset values.

Optional Feature:
- Macro SIGNAL_CHECKER_ERR_CAPTURE_EN.
- When defined, two extra outputs are present:
  - o_first_err_idx (CNT_WIDTH): the o_word_count value before increment of the first bad word.
  - o_first_err_lanes (CTRL_WIDTH): that word's bad-lane mask.
  - Both are captured once and held until reset or i_clear, which zero them and re-arm capture. A bad word at the same edge as i_clear is not captured.
- When undefined, these ports and their registers are absent and all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all counters 0, o_err 0, o_locked 0.
- All-data stream: 10 valid words, i_data=64'hAAAA_AAAA_AAAA_AAAA, i_ctrl=8'h00 -> word 10, data 80, ctrl 0, err 0. o_locked rises 2 cycles after the 4th word is presented.
- Mixed lanes: 5 words, i_ctrl=8'h0F, i_data=64'hAAAA_AAAA_5555_5555 -> data 20, ctrl 20, err 0, o_err never high.
- Errors:
  - Lock first, then send 2 words with lane 0 = 8'h00 (ctrl 0), then 1 good word -> err 2, two o_err pulses, o_locked stays 1.
  - Then send 3 such bad words -> err 5, o_locked falls after the 3rd.
- Gaps and clear: interleave i_valid=0 cycles between the 4 lock words -> lock still achieved. Assert i_clear for 1 cycle mid-stream -> counters read 0, then resume counting; o_locked unchanged.
- Saturation: with CNT_WIDTH=4, send 2 all-data words -> o_data_count=15 (no wrap), o_word_count=2. With SIGNAL_CHECKER_ERR_CAPTURE_EN defined, a bad 3rd word with lanes 1 and 6 bad -> o_first_err_idx=2, o_first_err_lanes=8'h42.

Source files
------------

// File: rtl/signal_checker.sv
// signal_checker: checks the signal_generator word stream lane by lane,
// keeps saturating word/lane statistics and tracks stream lock.
// Optional feature macro: SIGNAL_CHECKER_ERR_CAPTURE_EN adds first-error
// capture outputs (o_first_err_idx, o_first_err_lanes).
// Handshake: i_valid qualifies i_data/i_ctrl at every rising edge; there is
// no backpressure, so every valid word is consumed in the cycle it is shown.
module signal_checker #(
  parameter int         DATA_WIDTH        = 64,
  parameter int         CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
  parameter logic [7:0] CTRL_CHAR_PATTERN = 8'h55,
  parameter int         CNT_WIDTH         = 32,
  parameter int         LOCK_COUNT        = 4,
  parameter int         UNLOCK_ERRORS     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic                  i_clear,
  output logic [CNT_WIDTH-1:0]  o_word_count,
  output logic [CNT_WIDTH-1:0]  o_data_count,
  output logic [CNT_WIDTH-1:0]  o_ctrl_count,
  output logic [CNT_WIDTH-1:0]  o_err_count,
  output logic                  o_err,
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
  output logic [CNT_WIDTH-1:0]  o_first_err_idx,
  output logic [CTRL_WIDTH-1:0] o_first_err_lanes,
`endif
  output logic                  o_locked
);

  localparam int POP_W  = $clog2(CTRL_WIDTH + 1);
  localparam int SUM_W  = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;
  localparam int GRUN_W = $clog2(LOCK_COUNT + 1);
  localparam int BRUN_W = $clog2(UNLOCK_ERRORS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [CTRL_WIDTH-1:0] m);
    logic [POP_W-1:0] n;
    n = '0;
    for (int k = 0; k < CTRL_WIDTH; k++) n = n + POP_W'(m[k]);
    return n;
  endfunction

  // Add in a wider sum so an overflow can be seen and clamped to all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [POP_W-1:0]     p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(c) + SUM_W'(p);
    if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
    return s[CNT_WIDTH-1:0];
  endfunction

  logic [CTRL_WIDTH-1:0] good_data_mask, good_ctrl_mask, bad_mask;
  logic                  s1_valid_q;
  logic [CTRL_WIDTH-1:0] s1_data_mask_q, s1_ctrl_mask_q, s1_bad_mask_q;
  logic                  word_bad;
  logic [CNT_WIDTH-1:0]  word_cnt_q, data_cnt_q, ctrl_cnt_q, err_cnt_q;
  logic [CNT_WIDTH-1:0]  word_cnt_d, data_cnt_d, ctrl_cnt_d, err_cnt_d;
  state_t                state_q;
  logic [GRUN_W-1:0]     good_run_q;
  logic [BRUN_W-1:0]     bad_run_q;
  logic                  locked_q, err_q;

  // Classify every byte lane against the generator's fixed characters.
  always_comb begin
    good_data_mask = '0;
    good_ctrl_mask = '0;
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      good_data_mask[k] = !i_ctrl[k] && (i_data[8*k +: 8] == DATA_CHAR_PATTERN);
      good_ctrl_mask[k] =  i_ctrl[k] && (i_data[8*k +: 8] == CTRL_CHAR_PATTERN);
    end
    bad_mask = ~(good_data_mask | good_ctrl_mask);
  end

  // Stage 1: register the word qualifier and the three lane masks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q     <= 1'b0;
      s1_data_mask_q <= '0;
      s1_ctrl_mask_q <= '0;
      s1_bad_mask_q  <= '0;
    end else begin
      s1_valid_q     <= i_valid;
      s1_data_mask_q <= good_data_mask;
      s1_ctrl_mask_q <= good_ctrl_mask;
      s1_bad_mask_q  <= bad_mask;
    end
  end

  assign word_bad = |s1_bad_mask_q;

  // Stage 2 counter next-state: clear wins over the word leaving stage 1.
  always_comb begin
    word_cnt_d = word_cnt_q;
    data_cnt_d = data_cnt_q;
    ctrl_cnt_d = ctrl_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (i_clear) begin
      word_cnt_d = '0;
      data_cnt_d = '0;
      ctrl_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (s1_valid_q) begin
      word_cnt_d = sat_add(word_cnt_q, POP_W'(1));
      data_cnt_d = sat_add(data_cnt_q, popcount(s1_data_mask_q));
      ctrl_cnt_d = sat_add(ctrl_cnt_q, popcount(s1_ctrl_mask_q));
      err_cnt_d  = sat_add(err_cnt_q,  popcount(s1_bad_mask_q));
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_cnt_q <= '0;
      data_cnt_q <= '0;
      ctrl_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      data_cnt_q <= data_cnt_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Lock FSM with its registered outputs; i_clear does not touch it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_HUNT;
      good_run_q <= '0;
      bad_run_q  <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= s1_valid_q && word_bad;
      if (s1_valid_q) begin
        case (state_q)
          ST_HUNT: begin
            if (word_bad) begin
              good_run_q <= '0;
            end else if (good_run_q == GRUN_W'(LOCK_COUNT - 1)) begin
              state_q    <= ST_LOCKED;
              locked_q   <= 1'b1;
              good_run_q <= '0;
              bad_run_q  <= '0;
            end else begin
              good_run_q <= good_run_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!word_bad) begin
              bad_run_q <= '0;
            end else if (bad_run_q == BRUN_W'(UNLOCK_ERRORS - 1)) begin
              state_q    <= ST_HUNT;
              locked_q   <= 1'b0;
              bad_run_q  <= '0;
              good_run_q <= '0;
            end else begin
              bad_run_q <= bad_run_q + 1'b1;
            end
          end
          default: begin
            state_q  <= ST_HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
  logic                  cap_done_q;
  logic [CNT_WIDTH-1:0]  cap_idx_q;
  logic [CTRL_WIDTH-1:0] cap_lanes_q;

  // Capture the index and lane mask of the first bad word since reset/clear.
  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      cap_done_q  <= 1'b0;
      cap_idx_q   <= '0;
      cap_lanes_q <= '0;
    end else if (s1_valid_q && word_bad && !cap_done_q) begin
      cap_done_q  <= 1'b1;
      cap_idx_q   <= word_cnt_q;
      cap_lanes_q <= s1_bad_mask_q;
    end
  end

  assign o_first_err_idx   = cap_idx_q;
  assign o_first_err_lanes = cap_lanes_q;
`endif

  assign o_word_count = word_cnt_q;
  assign o_data_count = data_cnt_q;
  assign o_ctrl_count = ctrl_cnt_q;
  assign o_err_count  = err_cnt_q;
  assign o_err        = err_q;
  assign o_locked     = locked_q;

endmodule

// File: tb/tb_signal_checker.sv
// tb_signal_checker: table vectors, directed multi-cycle sequences and
// random traffic for signal_checker, run on a 32-bit-counter instance and a
// 4-bit-counter instance side by side against a word-level reference model.
module tb_signal_checker;

  localparam int LOCK_COUNT    = 4;
  localparam int UNLOCK_ERRORS = 3;
  localparam logic [63:0] ALL_AA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] MIXED  = 64'hAAAA_AAAA_5555_5555;
  localparam logic [63:0] BAD_L0 = 64'hAAAA_AAAA_AAAA_AA00;
  localparam logic [63:0] BAD_16 = 64'hAA00_AAAA_AAAA_00AA;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    int          n_data;
    int          n_ctrl;
    int          n_bad;
  } vec_t;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [7:0]  c;
  } word_t;

  // clock / reset / inputs
  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [63:0] i_data;
  logic [7:0]  i_ctrl;
  logic        i_clear;

  always #5 clk = ~clk;

  logic [31:0] w32_word, w32_data, w32_ctrl, w32_errc;
  logic        w32_err, w32_lock;
  logic [3:0]  w4_word, w4_data, w4_ctrl, w4_errc;
  logic        w4_err, w4_lock;
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
  logic [31:0] w32_cidx;
  logic [7:0]  w32_clanes;
  logic [3:0]  w4_cidx;
  logic [7:0]  w4_clanes;
`endif

  signal_checker dut32 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_ctrl(i_ctrl),
    .i_clear(i_clear), .o_word_count(w32_word), .o_data_count(w32_data),
    .o_ctrl_count(w32_ctrl), .o_err_count(w32_errc), .o_err(w32_err),
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
    .o_first_err_idx(w32_cidx), .o_first_err_lanes(w32_clanes),
`endif
    .o_locked(w32_lock)
  );

  signal_checker #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_ctrl(i_ctrl),
    .i_clear(i_clear), .o_word_count(w4_word), .o_data_count(w4_data),
    .o_ctrl_count(w4_ctrl), .o_err_count(w4_errc), .o_err(w4_err),
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
    .o_first_err_idx(w4_cidx), .o_first_err_lanes(w4_clanes),
`endif
    .o_locked(w4_lock)
  );

  // scoreboard / reference model state
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  word_t pend[$];
  longint unsigned raw_word, raw_data, raw_ctrl, raw_err;
  bit m_err, m_locked;
  int good_run, bad_run;
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
  bit              cap_done;
  longint unsigned cap_idx_raw;
  logic [7:0]      cap_lanes;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned raw, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  function automatic void classify(input logic [63:0] d, input logic [7:0] c,
                                   output int nd, output int nc, output int nb,
                                   output logic [7:0] bm);
    logic [7:0] b;
    nd = 0; nc = 0; nb = 0; bm = '0;
    for (int k = 0; k < 8; k++) begin
      b = d[8*k +: 8];
      if (!c[k] && b == 8'hAA) nd++;
      else if (c[k] && b == 8'h55) nc++;
      else begin
        nb++;
        bm[k] = 1'b1;
      end
    end
  endfunction

  // Word-level model: a word shown at one edge takes effect at the next.
  task automatic model_edge(input logic v, input logic [63:0] d, input logic [7:0] c,
                            input logic clr);
    word_t w;
    int nd, nc, nb;
    logic [7:0] bm;
    if (!rst) begin
      raw_word = 0; raw_data = 0; raw_ctrl = 0; raw_err = 0;
      m_err = 0; m_locked = 0; good_run = 0; bad_run = 0;
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
      cap_done = 0; cap_idx_raw = 0; cap_lanes = 0;
`endif
      pend.delete();
      pend.push_back('{1'b0, 64'd0, 8'd0});
      return;
    end
    w = pend.pop_front();
    m_err = 0;
    if (clr) begin
      raw_word = 0; raw_data = 0; raw_ctrl = 0; raw_err = 0;
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
      cap_done = 0; cap_idx_raw = 0; cap_lanes = 0;
`endif
    end
    if (w.v) begin
      classify(w.d, w.c, nd, nc, nb, bm);
      if (!clr) begin
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
        if (nb > 0 && !cap_done) begin
          cap_done = 1; cap_idx_raw = raw_word; cap_lanes = bm;
        end
`endif
        raw_word += 1;
        raw_data += longint'(nd);
        raw_ctrl += longint'(nc);
        raw_err  += longint'(nb);
      end
      m_err = (nb > 0);
      if (!m_locked) begin
        if (nb > 0) good_run = 0;
        else begin
          good_run++;
          if (good_run >= LOCK_COUNT) begin
            m_locked = 1; bad_run = 0; good_run = 0;
          end
        end
      end else begin
        if (nb == 0) bad_run = 0;
        else begin
          bad_run++;
          if (bad_run >= UNLOCK_ERRORS) begin
            m_locked = 0; good_run = 0; bad_run = 0;
          end
        end
      end
    end
    pend.push_back('{v, d, c});
  endtask

  task automatic compare_all();
    chk("w32_word",   64'(w32_word), sat(raw_word, 32));
    chk("w32_data",   64'(w32_data), sat(raw_data, 32));
    chk("w32_ctrl",   64'(w32_ctrl), sat(raw_ctrl, 32));
    chk("w32_errcnt", 64'(w32_errc), sat(raw_err, 32));
    chk("w32_err",    64'(w32_err),  64'(m_err));
    chk("w32_lock",   64'(w32_lock), 64'(m_locked));
    chk("w4_word",    64'(w4_word),  sat(raw_word, 4));
    chk("w4_data",    64'(w4_data),  sat(raw_data, 4));
    chk("w4_ctrl",    64'(w4_ctrl),  sat(raw_ctrl, 4));
    chk("w4_errcnt",  64'(w4_errc),  sat(raw_err, 4));
    chk("w4_err",     64'(w4_err),   64'(m_err));
    chk("w4_lock",    64'(w4_lock),  64'(m_locked));
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
    chk("w32_cap_idx",   64'(w32_cidx),   cap_done ? sat(cap_idx_raw, 32) : 64'd0);
    chk("w32_cap_lanes", 64'(w32_clanes), 64'(cap_lanes));
    chk("w4_cap_idx",    64'(w4_cidx),    cap_done ? sat(cap_idx_raw, 4) : 64'd0);
    chk("w4_cap_lanes",  64'(w4_clanes),  64'(cap_lanes));
`endif
  endtask

  // driver: one clock per call, inputs applied at the falling edge
  task automatic step(input logic v, input logic [63:0] d, input logic [7:0] c,
                      input logic clr);
    i_valid = v; i_data = d; i_ctrl = c; i_clear = clr;
    @(posedge clk);
    model_edge(v, d, c, clr);
    #1;
    compare_all();
    if (w32_err) pulse_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 8'd0, 1'b0);
  endtask

  function automatic void rand_word(output logic [63:0] d, output logic [7:0] c);
    int r;
    bit all_good;
    c = 8'($urandom);
    all_good = ($urandom_range(0, 9) < 7);
    for (int k = 0; k < 8; k++) begin
      r = all_good ? 0 : $urandom_range(0, 9);
      if (r < 7)       d[8*k +: 8] = c[k] ? 8'h55 : 8'hAA;
      else if (r < 9)  d[8*k +: 8] = c[k] ? 8'hAA : 8'h55;
      else             d[8*k +: 8] = 8'($urandom);
    end
  endfunction

  vec_t vecs[9];
  bit   err_seen;
  logic [63:0] rd;
  logic [7:0]  rc;

  initial begin
    vecs[0] = '{64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 8, 0, 0};
    vecs[1] = '{64'h5555_5555_5555_5555, 8'hFF, 0, 8, 0};
    vecs[2] = '{64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 0, 8};
    vecs[3] = '{64'hAAAA_AAAA_5555_5555, 8'h0F, 4, 4, 0};
    vecs[4] = '{64'h0000_0000_0000_0000, 8'h00, 0, 0, 8};
    vecs[5] = '{64'hAA55_AA55_AA55_AA55, 8'h55, 4, 4, 0};
    vecs[6] = '{64'hAA55_AA55_AA55_AA55, 8'hAA, 0, 0, 8};
    vecs[7] = '{64'hAAAA_AAAA_AAAA_AAAB, 8'h00, 7, 0, 1};
    vecs[8] = '{64'h55AA_AAAA_AAAA_AAAA, 8'h80, 7, 1, 0};

    rst = 1'b0; i_valid = 1'b0; i_data = '0; i_ctrl = '0; i_clear = 1'b0;
    pend.push_back('{1'b0, 64'd0, 8'd0});

    // reset held with random inputs
    for (int i = 0; i < 3; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
           1'($urandom_range(0, 1)));
    chk("rst_word", 64'(w32_word), 64'd0);
    chk("rst_data", 64'(w32_data), 64'd0);
    chk("rst_ctrl", 64'(w32_ctrl), 64'd0);
    chk("rst_errc", 64'(w32_errc), 64'd0);
    chk("rst_err",  64'(w32_err),  64'd0);
    chk("rst_lock", 64'(w32_lock), 64'd0);
    rst = 1'b1;

    // all-data stream; lock visible two edges after the 4th word
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ALL_AA, 8'h00, 1'b0);
      if (i == 3) chk("lock_not_yet", 64'(w32_lock), 64'd0);
      if (i == 4) chk("lock_rise",    64'(w32_lock), 64'd1);
    end
    idle(2);
    chk("alldata_word", 64'(w32_word), 64'd10);
    chk("alldata_data", 64'(w32_data), 64'd80);
    chk("alldata_ctrl", 64'(w32_ctrl), 64'd0);
    chk("alldata_errc", 64'(w32_errc), 64'd0);

    // mixed lanes
    step(1'b0, 64'd0, 8'd0, 1'b1);
    err_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(1'b1, MIXED, 8'h0F, 1'b0);
      else idle(1);
      err_seen |= w32_err;
    end
    chk("mixed_word",   64'(w32_word), 64'd5);
    chk("mixed_data",   64'(w32_data), 64'd20);
    chk("mixed_ctrl",   64'(w32_ctrl), 64'd20);
    chk("mixed_errc",   64'(w32_errc), 64'd0);
    chk("mixed_no_err", 64'(err_seen), 64'd0);

    // errors while locked: two bad words do not unlock, three do
    step(1'b0, 64'd0, 8'd0, 1'b1);
    pulse_cnt = 0;
    step(1'b1, BAD_L0, 8'h00, 1'b0);
    step(1'b1, BAD_L0, 8'h00, 1'b0);
    step(1'b1, ALL_AA, 8'h00, 1'b0);
    idle(2);
    chk("err2_count",  64'(w32_errc), 64'd2);
    chk("err2_pulses", 64'(pulse_cnt), 64'd2);
    chk("err2_lock",   64'(w32_lock), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b1, BAD_L0, 8'h00, 1'b0);
    idle(2);
    chk("err5_count",  64'(w32_errc), 64'd5);
    chk("err5_pulses", 64'(pulse_cnt), 64'd5);
    chk("err5_unlock", 64'(w32_lock), 64'd0);

    // table-driven single-word lane classification
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 64'd0, 8'd0, 1'b1);
      step(1'b1, vecs[i].data, vecs[i].ctrl, 1'b0);
      idle(1);
      chk($sformatf("vec%0d_word", i), 64'(w32_word), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(w32_data), 64'(vecs[i].n_data));
      chk($sformatf("vec%0d_ctrl", i), 64'(w32_ctrl), 64'(vecs[i].n_ctrl));
      chk($sformatf("vec%0d_bad", i),  64'(w32_errc), 64'(vecs[i].n_bad));
      chk($sformatf("vec%0d_pulse", i), 64'(w32_err), 64'(vecs[i].n_bad != 0));
    end

    // gaps between lock words, then a clear mid-stream
    rst = 1'b0; idle(1); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ALL_AA, 8'h00, 1'b0);
      idle(1);
    end
    chk("gap_lock", 64'(w32_lock), 64'd1);
    step(1'b1, ALL_AA, 8'h00, 1'b0);
    step(1'b1, ALL_AA, 8'h00, 1'b0);
    step(1'b1, ALL_AA, 8'h00, 1'b1);
    chk("clr_word", 64'(w32_word), 64'd0);
    chk("clr_data", 64'(w32_data), 64'd0);
    chk("clr_lock", 64'(w32_lock), 64'd1);
    idle(1);
    chk("clr_resume_word", 64'(w32_word), 64'd1);
    chk("clr_resume_data", 64'(w32_data), 64'd8);

    // saturation on the 4-bit instance and first-error capture
    rst = 1'b0; idle(1); rst = 1'b1;
    step(1'b1, ALL_AA, 8'h00, 1'b0);
    step(1'b1, ALL_AA, 8'h00, 1'b0);
    idle(1);
    chk("sat4_data",  64'(w4_data),  64'd15);
    chk("sat4_word",  64'(w4_word),  64'd2);
    chk("sat32_data", 64'(w32_data), 64'd16);
    step(1'b1, BAD_16, 8'h00, 1'b0);
    idle(1);
    chk("sat4_errc", 64'(w4_errc), 64'd2);
`ifdef SIGNAL_CHECKER_ERR_CAPTURE_EN
    chk("cap4_idx",   64'(w4_cidx),   64'd2);
    chk("cap4_lanes", 64'(w4_clanes), 64'h42);
    step(1'b1, BAD_L0, 8'h00, 1'b0);
    idle(1);
    chk("cap4_hold", 64'(w4_clanes), 64'h42);
`endif

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      rand_word(rd, rc);
      step(1'($urandom_range(0, 3) != 0), rd, rc, 1'($urandom_range(0, 49) == 0));
    end
    rst = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
